// File: rtl/invader_bombs.sv
// invader_bombs: launches, moves and retires the swarm's downward bombs
// Inputs: clk, rst (async high), frame tick, done clear, swarm_x/swarm_bottom_y geometry,
// col_alive column mask, player_hit per slot. Outputs: bomb_active per slot,
// bomb_x/bomb_y packed 10 bits per slot (slot i at [10i+9:10i]), all registered.
module invader_bombs #(
  parameter int NUM_BOMBS     = 3,
  parameter int NUM_COLS      = 6,
  parameter int COL_PITCH     = 32,
  parameter int X_OFFSET      = 14,
  parameter int BOMB_STEP     = 4,
  parameter int BOTTOM_Y      = 470,
  parameter int FIRE_INTERVAL = 40
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    frame,
  input  logic                    done,
  input  logic [9:0]              swarm_x,
  input  logic [9:0]              swarm_bottom_y,
  input  logic [NUM_COLS-1:0]     col_alive,
  input  logic [NUM_BOMBS-1:0]    player_hit,
  output logic [NUM_BOMBS-1:0]    bomb_active,
  output logic [10*NUM_BOMBS-1:0] bomb_x,
  output logic [10*NUM_BOMBS-1:0] bomb_y
);
  logic [9:0] lfsr;
  logic [7:0] cooldown;
  logic [2:0] start;
  logic [2:0] idx;
  logic [2:0] col;
  logic       has_col;
  logic [1:0] free_slot;
  logic       has_free;
  logic [9:0] launch_x;
  // scan downward so the last hit wins, leaving the first alive column from start
  always_comb begin
    start = (lfsr[2:0] >= 3'(NUM_COLS)) ? lfsr[2:0] - 3'(NUM_COLS) : lfsr[2:0];
    idx = '0;
    col = '0;
    has_col = 1'b0;
    for (int k = NUM_COLS - 1; k >= 0; k--) begin
      idx = 3'((int'(start) + k) % NUM_COLS);
      if (col_alive[idx]) begin
        col = idx;
        has_col = 1'b1;
      end
    end
    free_slot = '0;
    has_free = 1'b0;
    for (int i = NUM_BOMBS - 1; i >= 0; i--) begin
      if (!bomb_active[i]) begin
        free_slot = 2'(i);
        has_free = 1'b1;
      end
    end
    launch_x = swarm_x + 10'(col) * 10'(COL_PITCH) + 10'(X_OFFSET);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr <= 10'h001;
      cooldown <= 8'(FIRE_INTERVAL);
      bomb_active <= '0;
      bomb_x <= '0;
      bomb_y <= '0;
    end else begin
      lfsr <= {lfsr[8:0], lfsr[9] ^ lfsr[6]};
      if (done) begin
        bomb_active <= '0;
        cooldown <= 8'(FIRE_INTERVAL);
      end else begin
        for (int i = 0; i < NUM_BOMBS; i++) begin
          if (bomb_active[i] && player_hit[i])
            bomb_active[i] <= 1'b0;
          else if (frame && bomb_active[i]) begin
            if ({1'b0, bomb_y[i*10 +: 10]} + 11'(BOMB_STEP) >= 11'(BOTTOM_Y))
              bomb_active[i] <= 1'b0;
            else
              bomb_y[i*10 +: 10] <= bomb_y[i*10 +: 10] + 10'(BOMB_STEP);
          end
        end
        // free_slot comes from start-of-cycle state, so a slot freed now is not reused until next frame
        if (frame) begin
          if (cooldown != 8'd0)
            cooldown <= cooldown - 8'd1;
          else if (has_col && has_free) begin
            bomb_active[free_slot] <= 1'b1;
            bomb_x[free_slot*10 +: 10] <= launch_x;
            bomb_y[free_slot*10 +: 10] <= swarm_bottom_y;
            cooldown <= 8'(FIRE_INTERVAL);
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_invader_bombs.sv
// tb_invader_bombs: directed self-checking bench for invader_bombs
module tb_invader_bombs;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame = 1'b0;
  logic        done = 1'b0;
  logic [9:0]  swarm_x = 10'd100;
  logic [9:0]  swarm_bottom_y = 10'd200;
  logic [5:0]  col_alive = 6'b000100;
  logic [2:0]  player_hit = 3'b000;
  logic [2:0]  act, f_act;
  logic [29:0] bx, by, f_bx, f_by;
  int n_checks = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  invader_bombs dut (
    .clk(clk), .rst(rst), .frame(frame), .done(done), .swarm_x(swarm_x),
    .swarm_bottom_y(swarm_bottom_y), .col_alive(col_alive), .player_hit(player_hit),
    .bomb_active(act), .bomb_x(bx), .bomb_y(by)
  );
  invader_bombs #(.FIRE_INTERVAL(4)) u_fast (
    .clk(clk), .rst(rst), .frame(frame), .done(done), .swarm_x(swarm_x),
    .swarm_bottom_y(swarm_bottom_y), .col_alive(col_alive), .player_hit(player_hit),
    .bomb_active(f_act), .bomb_x(f_bx), .bomb_y(f_by)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic frames(input int n);
    for (int k = 0; k < n; k++) begin
      frame = 1'b1;
      @(negedge clk);
      frame = 1'b0;
      @(negedge clk);
    end
  endtask
  task automatic pulse_done;
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    @(negedge clk);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_active", 32'(act), 0);
    chk("reset_x", 32'(bx), 0);
    chk("reset_y", 32'(by), 0);
    frames(40);
    chk("cooldown_no_launch", 32'(act), 0);
    frames(1);
    chk("launch_active", 32'(act), 3'b001);
    chk("launch_x0", 32'(bx[9:0]), 178);
    chk("launch_y0", 32'(by[9:0]), 200);
    frames(1);
    chk("move_y0", 32'(by[9:0]), 204);
    col_alive = 6'b000001;
    swarm_bottom_y = 10'd460;
    frames(40);
    chk("wrap_active", 32'(act), 3'b011);
    chk("wrap_x1", 32'(bx[19:10]), 114);
    chk("wrap_y1", 32'(by[19:10]), 460);
    chk("wrap_y0", 32'(by[9:0]), 364);
    frames(1);
    chk("bottom_y1_464", 32'(by[19:10]), 464);
    frames(1);
    chk("bottom_y1_468", 32'(by[19:10]), 468);
    frames(1);
    chk("bottom_retire", 32'(act), 3'b001);
    chk("bottom_hold_y1", 32'(by[19:10]), 468);
    col_alive = 6'b000000;
    frames(100);
    chk("no_target_active", 32'(act), 0);
    col_alive = 6'b000100;
    swarm_bottom_y = 10'd200;
    frames(1);
    chk("retry_launch", 32'(act), 3'b001);
    chk("retry_x0", 32'(bx[9:0]), 178);
    chk("retry_y0", 32'(by[9:0]), 200);
    pulse_done();
    chk("done_clear", 32'(act), 0);
    chk("done_hold_y0", 32'(by[9:0]), 200);
    chk("done_clear_fast", 32'(f_act), 0);
    swarm_bottom_y = 10'd0;
    frames(20);
    chk("full_active", 32'(f_act), 3'b111);
    chk("full_y0", 32'(f_by[9:0]), 60);
    chk("main_waiting", 32'(act), 0);
    player_hit = 3'b010;
    frames(1);
    player_hit = 3'b000;
    chk("hit_active", 32'(f_act), 3'b101);
    chk("hit_y1_hold", 32'(f_by[19:10]), 40);
    chk("hit_y0_move", 32'(f_by[9:0]), 64);
    frames(1);
    chk("refill_active", 32'(f_act), 3'b111);
    chk("refill_y1", 32'(f_by[19:10]), 0);
    chk("refill_x1", 32'(f_bx[19:10]), 178);
    pulse_done();
    chk("done_three_clear", 32'(f_act), 0);
    frames(40);
    chk("done_wait_40", 32'(act), 0);
    frames(1);
    chk("done_launch_41", 32'(act), 3'b001);
    chk("done_launch_y0", 32'(by[9:0]), 0);
    frames(41);
    chk("second_launch", 32'(act), 3'b011);
    chk("second_y0", 32'(by[9:0]), 164);
    #2 rst = 1'b1;
    #1;
    chk("async_active", 32'(act), 0);
    chk("async_x", 32'(bx), 0);
    chk("async_y", 32'(by), 0);
    @(negedge clk);
    rst = 1'b0;
    frames(40);
    chk("post_reset_wait", 32'(act), 0);
    frames(1);
    chk("post_reset_launch", 32'(act), 3'b001);
    chk("post_reset_x0", 32'(bx[9:0]), 178);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
